// File: rtl/id_ex_skid_pkg.sv
// Shared constants and state encoding for the ID->EX handshake register.
// NOP constants carry the MIPS core's defines.v values.
package id_ex_skid_pkg;

  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/id_ex_skid_pipe_slot.sv
// One payload register of the ID->EX stage: loads a flattened payload or
// returns to the NOP pattern on reset/clear.
module pipe_slot #(
  parameter int           W   = 1,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload is reset, not just the valid bit, because execute relies
  // on a bubble always looking like a NOP.
  always_ff @(posedge clk) begin
    if (rst || clear) q <= NOP;
    else if (load)    q <= d;
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic                id_in_dslot,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_pc,
  output logic                ex_in_dslot,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PAY_W = ALUOP_W + ALUSEL_W + 3 * DATA_W + ADDR_W + 2;
  localparam logic [PAY_W-1:0] NOP_PAYLOAD = {
    ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP), DATA_W'(ZeroWord),
    DATA_W'(ZeroWord), ADDR_W'(NOPRegAddr), WriteDisable, DATA_W'(ZeroWord), 1'b0
  };

  pipe_state_e      state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_load, main_from_skid, main_clear;
  logic             skid_load, skid_clear;
  logic [PAY_W-1:0] id_payload, main_d, main_q, skid_q;

  assign id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_pc, id_in_dslot};
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_pc, ex_in_dslot} = main_q;

  assign out_valid = (state_q != PIPE_EMPTY);
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Skid variant decouples decode from out_ready; the single-entry variant
  // trades that for half the storage and a combinational ready path.
  if (SKID != 0) begin : g_ready_skid
    assign in_ready = ~rst & (state_q != PIPE_FULL);
  end else begin : g_ready_direct
    assign in_ready = ~rst & (~out_valid | out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= PIPE_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = PIPE_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        PIPE_EMPTY: if (in_fire) begin
          state_d   = PIPE_ONE;
          main_load = 1'b1;
        end
        PIPE_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = PIPE_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d    = PIPE_EMPTY;
            main_clear = 1'b1;
          end
        end
        PIPE_FULL: if (out_fire) begin
          state_d        = PIPE_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : id_payload;

  pipe_slot #(.W(PAY_W), .NOP(NOP_PAYLOAD)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.W(PAY_W), .NOP(NOP_PAYLOAD)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (id_payload),
      .q     (skid_q)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign skid_q      = NOP_PAYLOAD;
    assign unused_skid = skid_load ^ skid_clear;
  end

  always_ff @(posedge clk) begin
    if (rst)                                          stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
